// File: rtl/mcu_mem_pkg.sv
// Shared memory-subsystem definitions: refill FSM states, line geometry and
// the L2 free-space helper.
package mcu_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DATA  = 2'd2,
    ST_DRAIN = 2'd3
  } refill_state_e;

  localparam int LINE_BYTES     = 16;
  localparam int L2_WORDS       = 4096;
  localparam int WORDS_PER_LINE = 8;

  // Unread size counts 16-bit words; one 128-bit line holds eight of them.
  function automatic logic [8:0] free_lines(input logic [11:0] unread);
    logic [11:0] room;
    room = 12'hFFF - unread;
    return room[11:3];
  endfunction

endpackage

// File: rtl/l2_refill_fsm.sv
// Refill sequencing: IDLE/REQ/DATA/DRAIN state machine with the per-burst
// beat counter and the inter-beat idle (timeout) counter.
module l2_refill_fsm
  import mcu_mem_pkg::*;
#(
  parameter int BURST_LINES = 8,
  parameter int TIMEOUT     = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          ack,
  input  logic          valid,
  input  logic          conflict,
  output refill_state_e state,
  output logic          ready,
  output logic          accept,
  output logic          enter_req,
  output logic          timeout_hit
);

  localparam logic [3:0] LAST_BEAT  = 4'(BURST_LINES - 1);
  localparam logic [7:0] IDLE_LIMIT = 8'(TIMEOUT - 1);

  refill_state_e state_r;
  refill_state_e state_s;
  logic [3:0]    beat_cnt_r;
  logic [7:0]    idle_cnt_r;

  // State register plus beat/idle counters; both counters clear outside DATA.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      beat_cnt_r <= 4'd0;
      idle_cnt_r <= 8'd0;
    end else begin
      state_r <= state_s;
      if (state_r != ST_DATA) begin
        beat_cnt_r <= 4'd0;
        idle_cnt_r <= 8'd0;
      end else if (accept) begin
        beat_cnt_r <= beat_cnt_r + 4'd1;
        idle_cnt_r <= 8'd0;
      end else if (idle_cnt_r != 8'hFF) begin
        idle_cnt_r <= idle_cnt_r + 8'd1;
      end else begin
        idle_cnt_r <= idle_cnt_r;
      end
    end
  end

  // Next-state and handshake decode.
  always_comb begin
    state_s     = state_r;
    ready       = 1'b0;
    accept      = 1'b0;
    enter_req   = 1'b0;
    timeout_hit = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s   = ST_REQ;
          enter_req = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (ack) begin
          state_s = ST_DATA;
        end else begin
          state_s = ST_REQ;
        end
      end
      ST_DATA: begin
        ready  = !conflict;
        accept = !conflict && valid;
        if (accept) begin
          if (beat_cnt_r == LAST_BEAT) begin
            state_s = ST_DRAIN;
          end else begin
            state_s = ST_DATA;
          end
        end else if (idle_cnt_r >= IDLE_LIMIT) begin
          // This idle cycle brings the count to TIMEOUT.
          timeout_hit = 1'b1;
          state_s     = ST_IDLE;
        end else begin
          state_s = ST_DATA;
        end
      end
      ST_DRAIN: state_s = ST_IDLE;
      default:  state_s = ST_IDLE;
    endcase
  end

  assign state = state_r;

endmodule

// File: rtl/l2_ddr_refill.sv
// DDR-side L2 refill engine: issues fixed-length DDR burst reads when the L2
// has room and writes each returned 128-bit line into L2 port B.
module l2_ddr_refill
  import mcu_mem_pkg::*;
#(
  parameter int BURST_LINES = 8,
  parameter int DDR_ADDR_W  = 28,
  parameter int TIMEOUT     = 255
) (
  input  logic                  clk_166M66,
  input  logic                  mcu_sys_rst,
  input  logic                  i_refill_enable,
  input  logic                  i_base_load,
  input  logic [DDR_ADDR_W-1:0] i_base_address,
  input  logic [11:0]           i_l2_unread_size,
  input  logic                  i_l1ddr_rw_confilicts,
  output logic                  o_ddr_rd_req,
  output logic [DDR_ADDR_W-1:0] o_ddr_rd_addr,
  output logic [3:0]            o_ddr_rd_len,
  input  logic                  i_ddr_rd_ack,
  input  logic                  i_ddr_rd_valid,
  input  logic [127:0]          i_ddr_rd_data,
  output logic                  o_ddr_rd_ready,
  output logic                  o_l2_ddr_operate_enable,
  output logic                  o_l2_ddr_rw,
  output logic [127:0]          o_l2_ddr_data,
  output logic                  o_busy,
  output logic                  o_err,
  output logic [15:0]           o_lines_written
);

  localparam logic [DDR_ADDR_W-1:0] LINE_STEP  = DDR_ADDR_W'(LINE_BYTES);
  localparam logic [DDR_ADDR_W-1:0] ALIGN_MASK = ~DDR_ADDR_W'(LINE_BYTES - 1);

  refill_state_e         state_s;
  logic                  start_s;
  logic                  ready_s;
  logic                  accept_s;
  logic                  enter_req_s;
  logic                  timeout_s;
  logic [DDR_ADDR_W-1:0] fetch_ptr_r;
  logic [DDR_ADDR_W-1:0] rd_addr_r;
  logic [3:0]            rd_len_r;
  logic [127:0]          l2_data_r;
  logic                  l2_en_r;
  logic                  err_r;
  logic [15:0]           lines_r;

  assign start_s = i_refill_enable && !i_l1ddr_rw_confilicts &&
                   (free_lines(i_l2_unread_size) >= 9'(BURST_LINES));

  l2_refill_fsm #(
    .BURST_LINES (BURST_LINES),
    .TIMEOUT     (TIMEOUT)
  ) u_fsm (
    .clk         (clk_166M66),
    .rst         (mcu_sys_rst),
    .start       (start_s),
    .ack         (i_ddr_rd_ack),
    .valid       (i_ddr_rd_valid),
    .conflict    (i_l1ddr_rw_confilicts),
    .state       (state_s),
    .ready       (ready_s),
    .accept      (accept_s),
    .enter_req   (enter_req_s),
    .timeout_hit (timeout_s)
  );

  // Datapath: fetch pointer, latched request, L2 write stage and status.
  always_ff @(posedge clk_166M66) begin
    if (mcu_sys_rst) begin
      fetch_ptr_r <= '0;
      rd_addr_r   <= '0;
      rd_len_r    <= 4'd0;
      l2_data_r   <= 128'd0;
      l2_en_r     <= 1'b0;
      err_r       <= 1'b0;
      lines_r     <= 16'd0;
    end else begin
      l2_en_r <= accept_s;
      err_r   <= timeout_s;
      if (accept_s) begin
        l2_data_r   <= i_ddr_rd_data;
        fetch_ptr_r <= fetch_ptr_r + LINE_STEP;
        lines_r     <= lines_r + 16'd1;
      end else if (state_s == ST_IDLE && i_base_load) begin
        fetch_ptr_r <= i_base_address & ALIGN_MASK;
      end
      // Address/length stay frozen from REQ entry until the next burst.
      if (enter_req_s) begin
        rd_addr_r <= fetch_ptr_r;
        rd_len_r  <= 4'(BURST_LINES - 1);
      end
    end
  end

  assign o_ddr_rd_req            = (state_s == ST_REQ);
  assign o_ddr_rd_addr           = rd_addr_r;
  assign o_ddr_rd_len            = rd_len_r;
  assign o_ddr_rd_ready          = ready_s;
  assign o_l2_ddr_operate_enable = l2_en_r;
  assign o_l2_ddr_rw             = 1'b1;
  assign o_l2_ddr_data           = l2_data_r;
  assign o_busy                  = (state_s != ST_IDLE);
  assign o_err                   = err_r;
  assign o_lines_written         = lines_r;

endmodule
